// File: rtl/data_memory_arbiter.sv
// ============================================================================
// data_memory_arbiter
// ----------------------------------------------------------------------------
// Shares one single-port DataMemory between two requesters:
//   port A - CPU load/store stage
//   port B - DMA / debug loader
// An access takes three cycles: IDLE (arbitrate and latch the winner), ACCESS
// (drive the memory for one cycle), and RESPOND (pulse the owner's Ack).
// Read data is captured at the edge that ends ACCESS. The memory itself reads
// combinationally and writes on the falling clock edge.
//
// Build option:
//   DMARB_ROUND_ROBIN_EN  defined   -> on a tie, grant the port that did not
//                                      win last time (last_grant is tracked)
//                         undefined -> fixed priority, A always wins ties
//
// Parameters:
//   ADDR_W  word-address width (matches DataMemory Address)
//   DATA_W  data width
//
// Ports:
//   Clock         in   system clock, rising-edge logic
//   Reset         in   asynchronous, active-high
//   ReqA / ReqB   in   access request, held until the matching Ack
//   WeA / WeB     in   1 = write, 0 = read; stable while Req is high
//   AddrA / AddrB in   word address; stable while Req is high
//   WdataA/WdataB in   write data; stable while Req is high
//   AckA / AckB   out  one-cycle completion pulse, never both high
//   Rdata         out  registered read data, valid while AckA | AckB
//   Busy          out  high in ACCESS or RESPOND
//   MemAddress    out  to DataMemory Address
//   MemWriteData  out  to DataMemory WriteData
//   MemoryRead    out  to DataMemory MemoryRead (ACCESS only)
//   MemoryWrite   out  to DataMemory MemoryWrite (ACCESS only)
//   MemReadData   in   from DataMemory ReadData
// ============================================================================
module data_memory_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              ReqA,
    input  logic              ReqB,
    input  logic              WeA,
    input  logic              WeB,
    input  logic [ADDR_W-1:0] AddrA,
    input  logic [ADDR_W-1:0] AddrB,
    input  logic [DATA_W-1:0] WdataA,
    input  logic [DATA_W-1:0] WdataB,
    output logic              AckA,
    output logic              AckB,
    output logic [DATA_W-1:0] Rdata,
    output logic              Busy,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [DATA_W-1:0] MemWriteData,
    output logic              MemoryRead,
    output logic              MemoryWrite,
    input  logic [DATA_W-1:0] MemReadData
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ACCESS  = 2'b01,
        ST_RESPOND = 2'b10
    } state_e;

    // Owner encoding shared by owner_q and last_grant_q.
    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    state_e              state_q,     state_d;
    logic                owner_q,     owner_d;
    logic                we_q,        we_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic [DATA_W-1:0]   wdata_q,     wdata_d;
    logic                mem_read_q,  mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic                ack_a_q,     ack_a_d;
    logic                ack_b_q,     ack_b_d;
    logic [DATA_W-1:0]   rdata_q,     rdata_d;
    logic                busy_q,      busy_d;

    logic                req_any_s;
    logic                grant_b_s;
    logic                win_we_s;
    logic [ADDR_W-1:0]   win_addr_s;
    logic [DATA_W-1:0]   win_wdata_s;

`ifdef DMARB_ROUND_ROBIN_EN
    logic                last_grant_q, last_grant_d;
`endif

    // Arbitration: pick the winner among the current requests.
    always_comb begin
        req_any_s = ReqA | ReqB;
`ifdef DMARB_ROUND_ROBIN_EN
        // On a tie, B wins only if A took the previous grant.
        if (ReqA && ReqB) begin
            grant_b_s = (last_grant_q == OWNER_A);
        end else begin
            grant_b_s = ReqB;
        end
`else
        // Fixed priority: B wins only when A is not asking.
        if (ReqA) begin
            grant_b_s = 1'b0;
        end else begin
            grant_b_s = ReqB;
        end
`endif
    end

    // Winner's request fields, selected for latching on the grant edge.
    always_comb begin
        if (grant_b_s) begin
            win_we_s    = WeB;
            win_addr_s  = AddrB;
            win_wdata_s = WdataB;
        end else begin
            win_we_s    = WeA;
            win_addr_s  = AddrA;
            win_wdata_s = WdataA;
        end
    end

    // FSM next-state and registered-output next values.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        ack_a_d     = 1'b0;
        ack_b_d     = 1'b0;
        busy_d      = 1'b0;
`ifdef DMARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (req_any_s) begin
                    // Latch the winner; later changes on its inputs are ignored.
                    state_d     = ST_ACCESS;
                    owner_d     = grant_b_s ? OWNER_B : OWNER_A;
                    we_d        = win_we_s;
                    addr_d      = win_addr_s;
                    wdata_d     = win_wdata_s;
                    mem_write_d = win_we_s;
                    mem_read_d  = ~win_we_s;
                    busy_d      = 1'b1;
`ifdef DMARB_ROUND_ROBIN_EN
                    last_grant_d = grant_b_s ? OWNER_B : OWNER_A;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ACCESS: begin
                state_d = ST_RESPOND;
                busy_d  = 1'b1;
                ack_a_d = (owner_q == OWNER_A);
                ack_b_d = (owner_q == OWNER_B);
                // Capture read data at the edge that ends ACCESS; a write leaves
                // the previous read value in place.
                if (!we_q) begin
                    rdata_d = MemReadData;
                end else begin
                    rdata_d = rdata_q;
                end
            end

            ST_RESPOND: begin
                // No arbitration here, so a requester that drops Req on the
                // edge ending RESPOND is not granted again.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; Reset clears MemoryWrite immediately so a
    // write that has not reached its falling edge yet is suppressed.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWNER_A;
            we_q        <= 1'b0;
            addr_q      <= {ADDR_W{1'b0}};
            wdata_q     <= {DATA_W{1'b0}};
            rdata_q     <= {DATA_W{1'b0}};
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            ack_a_q     <= 1'b0;
            ack_b_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            ack_a_q     <= ack_a_d;
            ack_b_q     <= ack_b_d;
            busy_q      <= busy_d;
        end
    end

`ifdef DMARB_ROUND_ROBIN_EN
    // Round-robin history; B after reset so that A wins the first tie.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            last_grant_q <= OWNER_B;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    // Memory address/data hold their last values between accesses.
    assign MemAddress   = addr_q;
    assign MemWriteData = wdata_q;
    assign MemoryRead   = mem_read_q;
    assign MemoryWrite  = mem_write_q;
    assign AckA         = ack_a_q;
    assign AckB         = ack_b_q;
    assign Rdata        = rdata_q;
    assign Busy         = busy_q;

endmodule
